// File: rtl/param_seq_alu.sv
// Sequential signed add/sub, radix-4 Booth multiply and unsigned restoring divide.
// Latency: add/sub 1 cycle, multiply WIDTH/2 cycles, divide WIDTH cycles, then a one-cycle DONE (endd).
// No backpressure: bgn is sampled only in IDLE. Define PARAM_SEQ_ALU_DIV_EN to build the divider.
module param_seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bgn,
    input  logic [1:0]           op,
    input  logic [WIDTH-1:0]     operand1,
    input  logic [WIDTH-1:0]     operand2,
    output logic [2*WIDTH-1:0]   outbus,
    output logic                 endd,
    output logic                 busy,
    output logic                 ovf,
    output logic                 dbz,
    output logic                 err
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ADDSUB = 3'd1;
    localparam logic [2:0] S_MUL    = 3'd2;
`ifdef PARAM_SEQ_ALU_DIV_EN
    localparam logic [2:0] S_DIV    = 3'd3;
`endif
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]         state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, mc_q, mc_d;
    logic [WIDTH:0]     mq_q, mq_d;
    logic [2*WIDTH-1:0] outbus_q, outbus_d;
    logic               ovf_q, ovf_d, dbz_q, dbz_d, err_q, err_d;

    logic [WIDTH:0]     as_res;
    logic [2*WIDTH-1:0] pp, acc_nxt;

    // Booth digit from the low three bits of the shifting multiplier; mc_q already carries the 4^i weight.
    always_comb begin
        case (mq_q[2:0])
            3'b001, 3'b010: pp = mc_q;
            3'b011:         pp = mc_q << 1;
            3'b100:         pp = -(mc_q << 1);
            3'b101, 3'b110: pp = -mc_q;
            default:        pp = '0;
        endcase
        acc_nxt = acc_q + pp;
        as_res  = op_q[0] ? ({a_q[WIDTH-1], a_q} - {b_q[WIDTH-1], b_q})
                          : ({a_q[WIDTH-1], a_q} + {b_q[WIDTH-1], b_q});
    end

`ifdef PARAM_SEQ_ALU_DIV_EN
    logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, r_sub;
    logic [WIDTH:0]   r_sh;
    logic             ge;
    // A zero divisor makes every trial succeed, yielding all-ones quotient and remainder = dividend.
    always_comb begin
        r_sh  = {rem_q, quo_q[WIDTH-1]};
        ge    = (r_sh >= {1'b0, b_q});
        r_sub = r_sh[WIDTH-1:0] - b_q;
    end
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mc_d     = mc_q;
        mq_d     = mq_q;
        outbus_d = outbus_q;
        ovf_d    = ovf_q;
        dbz_d    = dbz_q;
        err_d    = err_q;
`ifdef PARAM_SEQ_ALU_DIV_EN
        rem_d    = rem_q;
        quo_d    = quo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bgn) begin
                    op_d  = op;
                    a_d   = operand1;
                    b_d   = operand2;
                    cnt_d = '0;
                    acc_d = '0;
                    mc_d  = {{WIDTH{operand1[WIDTH-1]}}, operand1};
                    mq_d  = {operand2, 1'b0};
`ifdef PARAM_SEQ_ALU_DIV_EN
                    rem_d = '0;
                    quo_d = operand1;
`endif
                    case (op)
                        2'b10:   state_d = S_MUL;
`ifdef PARAM_SEQ_ALU_DIV_EN
                        2'b11:   state_d = S_DIV;
`endif
                        default: state_d = S_ADDSUB;
                    endcase
                end
            end
            S_ADDSUB: begin
                state_d  = S_DONE;
                outbus_d = {{(WIDTH-1){as_res[WIDTH]}}, as_res};
                ovf_d    = as_res[WIDTH] ^ as_res[WIDTH-1];
                dbz_d    = 1'b0;
                err_d    = 1'b0;
`ifndef PARAM_SEQ_ALU_DIV_EN
                if (op_q == 2'b11) begin
                    outbus_d = '0;
                    ovf_d    = 1'b0;
                    err_d    = 1'b1;
                end
`endif
            end
            S_MUL: begin
                acc_d = acc_nxt;
                mc_d  = mc_q << 2;
                mq_d  = {2'b00, mq_q[WIDTH:2]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH/2 - 1)) begin
                    state_d  = S_DONE;
                    outbus_d = acc_nxt;
                    ovf_d    = 1'b0;
                    dbz_d    = 1'b0;
                    err_d    = 1'b0;
                end
            end
`ifdef PARAM_SEQ_ALU_DIV_EN
            S_DIV: begin
                rem_d = ge ? r_sub : r_sh[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], ge};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d  = S_DONE;
                    outbus_d = {rem_d, quo_d};
                    ovf_d    = 1'b0;
                    dbz_d    = (b_q == '0);
                    err_d    = 1'b0;
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mc_q     <= '0;
            mq_q     <= '0;
            outbus_q <= '0;
            ovf_q    <= 1'b0;
            dbz_q    <= 1'b0;
            err_q    <= 1'b0;
`ifdef PARAM_SEQ_ALU_DIV_EN
            rem_q    <= '0;
            quo_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mc_q     <= mc_d;
            mq_q     <= mq_d;
            outbus_q <= outbus_d;
            ovf_q    <= ovf_d;
            dbz_q    <= dbz_d;
            err_q    <= err_d;
`ifdef PARAM_SEQ_ALU_DIV_EN
            rem_q    <= rem_d;
            quo_q    <= quo_d;
`endif
        end
    end

    assign outbus = outbus_q;
    assign endd   = (state_q == S_DONE);
    assign busy   = (state_q != S_IDLE);
    assign ovf    = ovf_q;
    assign dbz    = dbz_q;
    assign err    = err_q;
endmodule

// File: tb/tb_param_seq_alu.sv
// Bench for param_seq_alu (WIDTH=8): directed literal cases plus randomized traffic checked every cycle
// against a transaction-level model; follows PARAM_SEQ_ALU_DIV_EN the same way the design does.
module tb_param_seq_alu;
    localparam int W = 8;

    logic           clk, rst, bgn;
    logic [1:0]     op;
    logic [W-1:0]   operand1, operand2;
    logic [2*W-1:0] outbus;
    logic           endd, busy, ovf, dbz, err;

    int n_vec  = 0;
    int n_miss = 0;

    param_seq_alu #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .bgn(bgn), .op(op),
        .operand1(operand1), .operand2(operand2),
        .outbus(outbus), .endd(endd), .busy(busy),
        .ovf(ovf), .dbz(dbz), .err(err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: cycles remaining until DONE, plus the result computed up front with plain arithmetic.
    int             m_left = 0;
    bit             m_done = 0;
    logic [2*W-1:0] m_out = '0, p_out = '0;
    bit             m_ovf = 0, m_dbz = 0, m_err = 0, p_ovf = 0, p_dbz = 0, p_err = 0;

    always @(posedge clk or negedge rst) begin
        longint sa, sb, r;
        logic [63:0] rr;
        logic [W-1:0] q, rm;
        if (!rst) begin
            m_left = 0; m_done = 0; m_out = '0; m_ovf = 0; m_dbz = 0; m_err = 0;
        end else if (m_done) begin
            m_done = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1; m_out = p_out; m_ovf = p_ovf; m_dbz = p_dbz; m_err = p_err;
            end
        end else if (bgn) begin
            sa = longint'($signed(operand1));
            sb = longint'($signed(operand2));
            p_ovf = 0; p_dbz = 0; p_err = 0;
            case (op)
                2'b00, 2'b01: begin
                    r = (op == 2'b00) ? sa + sb : sa - sb;
                    rr = r;
                    p_out = rr[2*W-1:0];
                    p_ovf = (r > 2**(W-1) - 1) || (r < -(2**(W-1)));
                    m_left = 1;
                end
                2'b10: begin
                    rr = sa * sb;
                    p_out = rr[2*W-1:0];
                    m_left = W / 2;
                end
                default: begin
`ifdef PARAM_SEQ_ALU_DIV_EN
                    if (operand2 == '0) begin
                        q = '1; rm = operand1; p_dbz = 1;
                    end else begin
                        q = operand1 / operand2; rm = operand1 % operand2;
                    end
                    p_out = {rm, q};
                    m_left = W;
`else
                    p_out = '0; p_err = 1;
                    m_left = 1;
`endif
                end
            endcase
        end
    end

    always @(negedge clk) begin
        chk("cycle", {busy, endd, ovf, dbz, err, outbus},
            {(m_left > 0 || m_done), m_done, m_ovf, m_dbz, m_err, m_out});
    end

    // Entered at posedge+2; returns at posedge+2. poke fires a stray bgn before edge n+2.
    task automatic run_op(input string name, input logic [1:0] o, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int exp_k, input logic [2*W-1:0] exp_out,
                          input logic exp_ovf, input logic exp_dbz, input logic exp_err, input bit poke);
        int lat;
        lat = 0;
        bgn = 1; op = o; operand1 = a; operand2 = b;
        @(posedge clk); #2;
        bgn = 0; operand1 = W'($urandom); operand2 = W'($urandom);
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            if (poke && k == 2) begin
                bgn = 1; op = 2'b00; operand1 = 8'd1; operand2 = 8'd1;
            end
            @(posedge clk); #1;
            bgn = 0;
            if (endd) lat = k;
        end
        chk({name, "_lat"}, lat, exp_k);
        chk({name, "_out"}, {ovf, dbz, err, outbus}, {exp_ovf, exp_dbz, exp_err, exp_out});
        @(posedge clk); #1;
        chk({name, "_pulse"}, {endd, busy}, 2'b00);
        #1;
    endtask

    initial begin
        logic [4:0] seq;
        rst = 1; bgn = 0; op = '0; operand1 = '0; operand2 = '0;
        #1 rst = 0;
        @(posedge clk); @(posedge clk); #2;
        chk("reset_state", {busy, endd, ovf, dbz, err, outbus}, '0);
        rst = 1;
        @(posedge clk); #2;

        run_op("add", 2'b00, 8'd100, 8'd50, 1, 16'h0096, 1, 0, 0, 0);
        run_op("mul", 2'b10, 8'hF9, 8'd6, 4, 16'hFFD6, 0, 0, 0, 1);
`ifdef PARAM_SEQ_ALU_DIV_EN
        run_op("div", 2'b11, 8'd144, 8'd5, 8, 16'h041C, 0, 0, 0, 0);
        run_op("div0", 2'b11, 8'd200, 8'd0, 8, 16'hC8FF, 0, 1, 0, 0);
`else
        run_op("nodiv", 2'b11, 8'd144, 8'd5, 1, 16'h0000, 0, 0, 1, 0);
`endif
        run_op("sub", 2'b01, 8'd5, 8'd10, 1, 16'hFFFB, 0, 0, 0, 0);
        run_op("mulpos", 2'b10, 8'd127, 8'h80, 4, 16'hC080, 0, 0, 0, 0);

        // Abort a multiply with reset after edge n+2.
        bgn = 1; op = 2'b10; operand1 = 8'd3; operand2 = 8'd3;
        @(posedge clk); #2 bgn = 0;
        @(posedge clk); @(posedge clk); #2;
        rst = 0; #1;
        chk("abort_now", {busy, endd, ovf, dbz, err, outbus}, '0);
        seq = '0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1 seq[k] = endd;
        end
        chk("abort_no_endd", seq, '0);
        #1 rst = 1;
        run_op("add_after_rst", 2'b00, 8'h80, 8'hFF, 1, 16'hFF7F, 1, 0, 0, 0);

        // bgn held high: captures at n and n+3, DONE after n+1 and n+4.
        bgn = 1; op = 2'b00; operand1 = 8'd1; operand2 = 8'd2;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1 seq[k] = endd;
        end
        bgn = 0;
        chk("b2b_endd", seq, 5'b01001);
        chk("b2b_out", outbus, 16'h0003);
        #1;

        for (int c = 0; c < 3000; c++) begin
            bgn = ($urandom_range(0, 1) == 1);
            op = 2'($urandom);
            operand1 = W'($urandom);
            operand2 = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            if ($urandom_range(0, 299) == 0) rst = 0;
            @(posedge clk); #2;
            rst = 1;
        end
        bgn = 0;
        repeat (12) @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/param_seq_alu.md
PARAM_SEQ_ALU -- requirements
Module: param_seq_alu

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, operand width; legal values are even integers 4..32.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-004 The block SHALL have port bgn  input  1  start request, sampled only in IDLE.
REQ-005 The block SHALL have port op  input  2  operation: 00 add, 01 sub, 10 signed multiply, 11 unsigned divide.
REQ-006 The block SHALL have ports operand1 and operand2  input  WIDTH  operands, captured on start.
REQ-007 The block SHALL have port outbus  output  2*WIDTH  result.
REQ-008 The block SHALL have port endd  output  1  one-cycle done pulse.
REQ-009 The block SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-010 The block SHALL have ports ovf, dbz and err  output  1 each: signed overflow, divide-by-zero, unsupported op.

Function
REQ-011 The FSM SHALL use states IDLE, ADDSUB, MUL, DIV, DONE; DONE lasts exactly one cycle, then IDLE.
REQ-012 In IDLE with bgn=1 at edge n, op/operands SHALL be latched; next state per op; bgn in any other state is ignored.
REQ-013 DONE SHALL be entered at edge n+K with K=1 (add/sub), WIDTH/2 (mul), WIDTH (div); endd=1 only while in DONE.
REQ-014 Add/sub SHALL treat operands as signed; outbus = WIDTH+1-bit exact result sign-extended to 2*WIDTH; ovf=1 if the WIDTH-bit truncated result overflows.
REQ-015 Multiply SHALL use radix-4 Booth recoding, one digit per cycle, WIDTH/2 cycles; outbus = exact signed 2*WIDTH product; ovf=0.
REQ-016 Divide SHALL be unsigned restoring, one quotient bit per cycle; outbus = {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}.
REQ-017 Divide with operand2=0 SHALL still take WIDTH cycles, give quotient all-ones, remainder=operand1, dbz=1.
REQ-018 outbus, ovf, dbz, err SHALL update only on the edge entering DONE and hold until the next DONE entry.
REQ-019 Operand inputs changing after capture SHALL NOT affect the result in progress.

Reset
REQ-020 rst=0 SHALL immediately force state IDLE and outbus=0, endd=0, busy=0, ovf=0, dbz=0, err=0.
REQ-021 Reset asserted mid-operation SHALL abort it with no endd; after release the block accepts bgn on the first edge.

Configuration
REQ-022 Macro PARAM_SEQ_ALU_DIV_EN defined: divider and DIV state compiled in, op 11 behaves per REQ-016/017, err stays 0.
REQ-023 Macro PARAM_SEQ_ALU_DIV_EN undefined: no divider logic; op 11 enters DONE at n+1 with outbus=0, err=1, dbz=0, ovf=0.

Verification (WIDTH=8, PARAM_SEQ_ALU_DIV_EN defined unless stated)
REQ-024 Add 100+50 -> DONE at n+1, outbus=16'h0096, ovf=1, endd one cycle.
REQ-025 Mul -7*6 -> DONE at n+4, outbus=16'hFFD6, ovf=0; bgn pulsed at n+2 with new operands is ignored.
REQ-026 Div 144/5 -> DONE at n+8, outbus=16'h041C, dbz=0; div 200/0 -> outbus=16'hC8FF, dbz=1.
REQ-027 Sub 5-10 -> outbus=16'hFFFB, ovf=0; then rst=0 at n+2 of a mul -> all outputs 0 at once, no endd, next add completes normally.
REQ-028 Macro undefined, op 11 -> DONE at n+1, outbus=0, err=1; back-to-back bgn held high -> new op starts at edge after DONE.
